pulse_period_monitor: RTL and testbench

Receiving end of the free-running control-pulse scheme. It samples a periodic one-cycle control pulse (such as a counter output asserted every EXP_PERIOD enabled cycles), measures the interval between pulses, and locks onto the expected period. Once locked, it flags early, late and missing pulses. It sits downstream of the pulse generator, in the same clock and clk_enable domain.

---
 rtl/pulse_period_monitor_if.sv | 32 +++
 rtl/pulse_period_monitor.sv | 159 +++++++++++++++
 tb/tb_pulse_period_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_period_monitor_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_period_monitor_if
// Bundles the sampled control pulse, its clock qualifier and the monitor
// status outputs into one connection.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface pulse_period_monitor_if #(
  parameter int N_BITS = 5
) ();
  logic              clk_enable;
  logic              i_pulse;
  logic              o_locked;
  logic              o_lost;
  logic              o_err;
  logic [N_BITS-1:0] o_period;
  logic              o_period_valid;
  logic [7:0]        o_pulse_cnt;

  // Side that produces the pulse and consumes the status
  modport master (
    output clk_enable, i_pulse,
    input  o_locked, o_lost, o_err, o_period, o_period_valid, o_pulse_cnt
  );

  // The monitor itself
  modport slave (
    input  clk_enable, i_pulse,
    output o_locked, o_lost, o_err, o_period, o_period_valid, o_pulse_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pulse_period_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_period_monitor
// Measures the interval between one-cycle control pulses, locks onto the
// expected period and then flags early, off-grid and missing pulses.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pulse_period_monitor #(
  parameter int N_BITS     = 5,
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  pulse_period_monitor_if.slave  bus
);

  localparam int PH_W = (EXP_PERIOD > 2) ? $clog2(EXP_PERIOD) : 1;
  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int EC_W = $clog2(MISS_LIMIT + 1);

  localparam logic [N_BITS-1:0] CNT_MAX   = {N_BITS{1'b1}};
  localparam logic [N_BITS-1:0] EXP_VAL   = N_BITS'(EXP_PERIOD);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(EXP_PERIOD - 1);
  localparam logic [MC_W-1:0]   MC_LAST   = MC_W'(LOCK_COUNT - 1);
  localparam logic [EC_W-1:0]   EC_LAST   = EC_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t            state;
  logic [N_BITS-1:0] cnt;
  logic [PH_W-1:0]   ph;
  logic [MC_W-1:0]   match_cnt;
  logic [EC_W-1:0]   err_cnt;
  logic              late_pending;

  logic              locked;
  logic              lost;
  logic              err;
  logic [N_BITS-1:0] period_q;
  logic              period_valid;
  logic [7:0]        pulse_cnt;

  logic              pulse;
  logic              slot_miss;
  logic [N_BITS-1:0] period;
  logic              is_match;

  // Event decode for the current cycle
  always_comb begin
    pulse     = bus.clk_enable & bus.i_pulse;
    slot_miss = bus.clk_enable & ~bus.i_pulse & (ph == PH_LAST);
    period    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    is_match  = pulse & (period == EXP_VAL) & ~late_pending;
  end

  // Counters, lock state machine and registered status outputs.
  // Strobes drop on every clock so they stay one cycle wide even when
  // clk_enable is toggling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ph           <= '0;
      match_cnt    <= '0;
      err_cnt      <= '0;
      late_pending <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
      err          <= 1'b0;
      period_q     <= '0;
      period_valid <= 1'b0;
      pulse_cnt    <= '0;
    end else begin
      err          <= 1'b0;
      period_valid <= 1'b0;
      if (bus.clk_enable) begin
        if (pulse) begin
          cnt          <= '0;
          ph           <= '0;
          pulse_cnt    <= pulse_cnt + 8'd1;
          late_pending <= 1'b0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
        end

        if (pulse && (state == MEASURE || state == LOCKED)) begin
          period_q     <= period;
          period_valid <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (pulse) begin
              state     <= MEASURE;
              match_cnt <= '0;
            end
          end
          MEASURE: begin
            if (is_match) begin
              if (match_cnt == MC_LAST) begin
                state     <= LOCKED;
                match_cnt <= '0;
                err_cnt   <= '0;
                locked    <= 1'b1;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else if (pulse || slot_miss) begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // A pulse arriving after a missed slot only re-aligns the phase
            if (is_match) begin
              err_cnt <= '0;
            end else if ((pulse && !late_pending) || slot_miss) begin
              err <= 1'b1;
              if (slot_miss) late_pending <= 1'b1;
              if (err_cnt == EC_LAST) begin
                state        <= LOST;
                err_cnt      <= '0;
                late_pending <= 1'b0;
                locked       <= 1'b0;
                lost         <= 1'b1;
              end else begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
          end
          LOST: begin
            if (pulse) begin
              state     <= MEASURE;
              match_cnt <= '0;
              lost      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_locked       = locked;
  assign bus.o_lost         = lost;
  assign bus.o_err          = err;
  assign bus.o_period       = period_q;
  assign bus.o_period_valid = period_valid;
  assign bus.o_pulse_cnt    = pulse_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pulse_period_monitor
// Drives directed and random pulse trains; a timing-level model predicts the
// status per cycle and a separate monitor compares DUT outputs to it.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pulse_period_monitor;

  localparam int N_BITS = 5;
  localparam int EXP    = 4;
  localparam int LOCK   = 3;
  localparam int MISS   = 2;
  localparam int SATV   = (1 << N_BITS) - 1;

  logic clk;
  logic reset;

  pulse_period_monitor_if #(.N_BITS(N_BITS)) dut_if ();

  pulse_period_monitor #(
    .N_BITS(N_BITS), .EXP_PERIOD(EXP), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              locked;
    logic              lost;
    logic              err;
    logic              valid;
    logic [N_BITS-1:0] period;
    logic [7:0]        pcnt;
  } exp_t;

  exp_t              sq[$];
  logic [N_BITS-1:0] pq[$];
  int                errors = 0;
  int                checks = 0;

  // Reference model: pulses are described by their distance in enabled
  // cycles; a slot is missed whenever that distance reaches a multiple of
  // the expected period. Modes: 0 idle, 1 measuring, 2 locked, 3 lost.
  int                m_mode, m_match, m_errs, m_since, m_pcnt;
  bit                m_late;
  logic [N_BITS-1:0] m_period;

  task automatic model_reset();
    m_mode = 0; m_match = 0; m_errs = 0; m_since = 1; m_pcnt = 0;
    m_late = 1'b0; m_period = '0;
  endtask

  task automatic cyc(input bit en, input bit p, input bit rst);
    exp_t e;
    int   per;
    @(negedge clk);
    reset = rst;
    dut_if.clk_enable = en;
    dut_if.i_pulse = p;
    e = '0;
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (p) begin
        per = (m_since > SATV) ? SATV : m_since;
        m_pcnt = (m_pcnt + 1) % 256;
        if (m_mode == 1 || m_mode == 2) begin
          e.valid = 1'b1;
          m_period = N_BITS'(per);
          pq.push_back(N_BITS'(per));
        end
        if (m_mode == 0 || m_mode == 3) begin
          m_mode = 1; m_match = 0;
        end else if (m_mode == 1) begin
          if (per == EXP) begin
            m_match++;
            if (m_match == LOCK) begin m_mode = 2; m_errs = 0; end
          end else m_match = 0;
        end else if (!m_late) begin
          if (per == EXP) m_errs = 0;
          else begin e.err = 1'b1; m_errs++; end
        end
        m_late = 1'b0;
        m_since = 1;
      end else begin
        if (m_since % EXP == 0) begin
          if (m_mode == 1) m_match = 0;
          if (m_mode == 2) begin e.err = 1'b1; m_errs++; m_late = 1'b1; end
        end
        m_since++;
      end
      if (m_mode == 2 && m_errs >= MISS) begin m_mode = 3; m_late = 1'b0; end
    end
    e.locked = (m_mode == 2);
    e.lost   = (m_mode == 3);
    e.period = m_period;
    e.pcnt   = 8'(m_pcnt);
    sq.push_back(e);
  endtask

  // Monitor: status every cycle, period payload whenever the DUT strobes it
  initial begin
    exp_t e;
    logic [N_BITS-1:0] ep;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        checks++;
        if (dut_if.o_locked !== e.locked || dut_if.o_lost !== e.lost ||
            dut_if.o_err !== e.err || dut_if.o_period_valid !== e.valid ||
            dut_if.o_period !== e.period || dut_if.o_pulse_cnt !== e.pcnt) begin
          errors++;
          $display("FAIL status @%0t: got locked=%b lost=%b err=%b valid=%b period=%0d cnt=%0d want locked=%b lost=%b err=%b valid=%b period=%0d cnt=%0d",
                   $time, dut_if.o_locked, dut_if.o_lost, dut_if.o_err,
                   dut_if.o_period_valid, dut_if.o_period, dut_if.o_pulse_cnt,
                   e.locked, e.lost, e.err, e.valid, e.period, e.pcnt);
        end
      end
      if (dut_if.o_period_valid === 1'b1) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL period @%0t: got unexpected strobe period=%0d want none",
                   $time, dut_if.o_period);
        end else begin
          ep = pq.pop_front();
          if (dut_if.o_period !== ep) begin
            errors++;
            $display("FAIL period @%0t: got %0d want %0d", $time, dut_if.o_period, ep);
          end
        end
      end
    end
  end

  // Pulse every EXP enabled cycles for k in [from,to), skipping listed slots
  task automatic train(input int from, input int to, input int skip_a, input int skip_b);
    for (int k = from; k < to; k++)
      cyc(1'b1, (k % EXP == 0) && k != skip_a && k != skip_b, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    dut_if.clk_enable = 1'b0;
    dut_if.i_pulse = 1'b0;
    model_reset();

    // Lock, then one missing slot followed by resync
    cyc(1'b0, 1'b0, 1'b1);
    train(0, 16, -1, -1);
    train(16, 32, 16, -1);

    // Two missing slots -> lost, then relock
    cyc(1'b0, 1'b0, 1'b1);
    train(0, 16, -1, -1);
    train(16, 44, 16, 20);

    // Early pulses at 14 and 16
    cyc(1'b0, 1'b0, 1'b1);
    train(0, 14, -1, -1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    // Toggling enable with spurious pulses on disabled cycles
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, (k % EXP == 0), 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
    end

    // Saturation of the interval counter in MEASURE
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    // Reset while locked
    cyc(1'b0, 1'b0, 1'b1);
    train(0, 18, -1, -1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);

    // Random jittered trains with gaps, extras and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit en, p, rst;
      int r;
      en  = ($urandom % 8) != 0;
      r   = $urandom % 100;
      rst = ($urandom % 1000) == 0;
      if (m_since == EXP)     p = (r < 85);
      else if (m_since > EXP) p = (r < 40);
      else                    p = (r < 4);
      cyc(en, p, rst);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL drain: got status=%0d period=%0d pending want 0", sq.size(), pq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
